// File: rtl/xform_stream_ctrl.sv
// Stream sequencer for the 3x4 matrix-vector transform: splits each frame into
// coefficient rows and vectors, meters vectors against output FIFO credits.
module xform_stream_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int ROWS       = 3,
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int DW = LANES * DATA_WIDTH,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          s00_axis_aclk,
    input  logic          s00_axis_areset,
    input  logic [DW-1:0] s00_axis_tdata,
    input  logic          s00_axis_tvalid,
    output logic          s00_axis_tready,
    input  logic          s00_axis_tlast,
    output logic          mat_we,
    output logic [RW-1:0] mat_row,
    output logic [DW-1:0] mat_wdata,
    output logic          vec_valid,
    output logic [DW-1:0] vec_data,
    output logic          vec_last,
    output logic          res_valid,
    output logic          res_last,
    input  logic          fifo_pop,
    output logic [CW-1:0] credit_occ,
    output logic [15:0]   frame_cnt,
    output logic          err_short
);

    typedef enum logic {LOAD, STREAM} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] row_cnt, row_nxt;
    logic          accept, ld_accept, st_accept, pop_ok;
    logic [PIPE_LAT-1:0] vpipe, lpipe;

    assign s00_axis_tready = (state == LOAD) ||
                             (credit_occ < CW'(FIFO_DEPTH));
    assign accept    = s00_axis_tvalid && s00_axis_tready;
    assign ld_accept = accept && (state == LOAD);
    assign st_accept = accept && (state == STREAM);
    assign pop_ok    = fifo_pop && (credit_occ != '0);

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state   <= LOAD;
            row_cnt <= '0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row_cnt;
        unique case (state)
            LOAD: begin
                if (accept) begin
                    if (s00_axis_tlast) begin
                        row_nxt = '0;
                    end else if (row_cnt == RW'(ROWS - 1)) begin
                        row_nxt   = '0;
                        state_nxt = STREAM;
                    end else begin
                        row_nxt = row_cnt + RW'(1);
                    end
                end
            end
            STREAM: begin
                if (accept && s00_axis_tlast)
                    state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            mat_we    <= 1'b0;
            mat_row   <= '0;
            mat_wdata <= '0;
            vec_valid <= 1'b0;
            vec_data  <= '0;
            vec_last  <= 1'b0;
            err_short <= 1'b0;
            frame_cnt <= '0;
        end else begin
            mat_we    <= ld_accept;
            vec_valid <= st_accept;
            vec_last  <= st_accept && s00_axis_tlast;
            err_short <= ld_accept && s00_axis_tlast;
            if (ld_accept) begin
                mat_row   <= row_cnt;
                mat_wdata <= s00_axis_tdata;
            end
            if (st_accept)
                vec_data <= s00_axis_tdata;
            if (st_accept && s00_axis_tlast)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Credits are taken at issue, so the FIFO always has room when a result lands.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            credit_occ <= '0;
        end else begin
            unique case ({st_accept, pop_ok})
                2'b10:   credit_occ <= credit_occ + CW'(1);
                2'b01:   credit_occ <= credit_occ - CW'(1);
                default: credit_occ <= credit_occ;
            endcase
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            vpipe <= '0;
            lpipe <= '0;
        end else begin
            vpipe[0] <= vec_valid;
            lpipe[0] <= vec_last;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                lpipe[i] <= lpipe[i-1];
            end
        end
    end

    assign res_valid = vpipe[PIPE_LAT-1];
    assign res_last  = lpipe[PIPE_LAT-1];

endmodule

// File: tb/tb_xform_stream_ctrl.sv
// Randomised and directed bench for xform_stream_ctrl; a frame-level model
// queues expected strobes and a monitor matches them as the DUT emits them.
module tb_xform_stream_ctrl;

    localparam int DEPTH = 4;
    localparam int LAT   = 3;
    localparam int NROWS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        tlast = 1'b0;
    logic        mat_we;
    logic [1:0]  mat_row;
    logic [63:0] mat_wdata;
    logic        vec_valid;
    logic [63:0] vec_data;
    logic        vec_last;
    logic        res_valid;
    logic        res_last;
    logic        fifo_pop = 1'b0;
    logic [2:0]  credit_occ;
    logic [15:0] frame_cnt;
    logic        err_short;

    xform_stream_ctrl #(
        .DATA_WIDTH(16), .LANES(4), .ROWS(NROWS),
        .PIPE_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_areset(rst),
        .s00_axis_tdata(tdata),
        .s00_axis_tvalid(tvalid),
        .s00_axis_tready(tready),
        .s00_axis_tlast(tlast),
        .mat_we(mat_we),
        .mat_row(mat_row),
        .mat_wdata(mat_wdata),
        .vec_valid(vec_valid),
        .vec_data(vec_data),
        .vec_last(vec_last),
        .res_valid(res_valid),
        .res_last(res_last),
        .fifo_pop(fifo_pop),
        .credit_occ(credit_occ),
        .frame_cnt(frame_cnt),
        .err_short(err_short)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [1:0] row; logic [63:0] data; } mat_t;
    typedef struct { int cyc; logic [63:0] data; logic last; } vec_t;
    typedef struct { int cyc; logic last; } res_t;

    mat_t mat_q[$];
    vec_t vec_q[$];
    res_t res_q[$];
    int   err_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // frame-level reference state
    logic   load_m;
    int     row_m;
    int     occ_m;
    int     frame_m;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic fail_ev(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event mismatch expected queued event (cycle %0d)",
                 nm, cyc);
    endtask

    function automatic logic [63:0] pack(input int a, b, c, d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic void model_reset();
        load_m  = 1'b1;
        row_m   = 0;
        occ_m   = 0;
        frame_m = 0;
        mat_q.delete();
        vec_q.delete();
        res_q.delete();
        err_q.delete();
    endfunction

    // One clock of stimulus; the model decides acceptance from its own credits.
    task automatic step(input logic v, input logic [63:0] d, input logic l,
                        input logic p, output logic acc);
        logic rdy;
        int   tgt;
        int   inc;
        int   dec;
        @(negedge clk);
        tvalid   = v;
        tdata    = d;
        tlast    = l;
        fifo_pop = p;
        #1;
        rdy = load_m || (occ_m < DEPTH);
        check("tready", tready, rdy);
        acc = v && rdy;
        tgt = cyc + 1;
        inc = 0;
        dec = 0;
        if (acc) begin
            if (load_m) begin
                mat_q.push_back('{tgt, 2'(row_m), d});
                if (l) begin
                    err_q.push_back(tgt);
                    row_m = 0;
                end else if (row_m == NROWS - 1) begin
                    row_m  = 0;
                    load_m = 1'b0;
                end else begin
                    row_m++;
                end
            end else begin
                vec_q.push_back('{tgt, d, l});
                res_q.push_back('{tgt + LAT, l});
                inc = 1;
                if (l) begin
                    frame_m = (frame_m + 1) & 16'hFFFF;
                    load_m  = 1'b1;
                end
            end
        end
        if (p && occ_m > 0) dec = 1;
        occ_m = occ_m + inc - dec;
    endtask

    function automatic logic pop_of(input int pm);
        if (pm == 2) return 1'($urandom_range(0, 1));
        return pm == 1;
    endfunction

    task automatic send(input logic [63:0] d, input logic l, input int pm);
        logic acc;
        int   n;
        n = 0;
        do begin
            step(1'b1, d, l, pop_of(pm), acc);
            n++;
        end while (!acc && n < 40);
        if (!acc) fail_ev("send_timeout");
    endtask

    task automatic idle(input int n, input int pm);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, pop_of(pm), acc);
    endtask

    task automatic nominal_frame(input int pm);
        send(pack(41, 0, 0, -20480), 1'b0, pm);
        send(pack(0, 41, 0, -16384), 1'b0, pm);
        send(pack(0, 0, 41, -17613), 1'b0, pm);
        send(pack(300, 800, 500, 1), 1'b0, pm);
        send(pack(600, 0, 400, 1), 1'b0, pm);
        send(pack(800, 500, 400, 1), 1'b0, pm);
        send(pack(25, 25, 25, 1), 1'b0, pm);
        send(pack(25, 25, 75, 1), 1'b1, pm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        tvalid   = 1'b0;
        tlast    = 1'b0;
        fifo_pop = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    mat_t m_e;
    vec_t v_e;
    res_t r_e;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (mat_we) begin
                if (mat_q.size() == 0) fail_ev("mat_unexpected");
                else begin
                    m_e = mat_q.pop_front();
                    check("mat_cycle", 64'(cyc), 64'(m_e.cyc));
                    check("mat_row", mat_row, m_e.row);
                    check("mat_wdata", mat_wdata, m_e.data);
                end
            end else if (mat_q.size() > 0 && mat_q[0].cyc <= cyc) begin
                fail_ev("mat_missing");
                void'(mat_q.pop_front());
            end
            if (vec_valid) begin
                if (vec_q.size() == 0) fail_ev("vec_unexpected");
                else begin
                    v_e = vec_q.pop_front();
                    check("vec_cycle", 64'(cyc), 64'(v_e.cyc));
                    check("vec_data", vec_data, v_e.data);
                    check("vec_last", vec_last, v_e.last);
                end
            end else if (vec_q.size() > 0 && vec_q[0].cyc <= cyc) begin
                fail_ev("vec_missing");
                void'(vec_q.pop_front());
            end
            if (res_valid) begin
                if (res_q.size() == 0) fail_ev("res_unexpected");
                else begin
                    r_e = res_q.pop_front();
                    check("res_cycle", 64'(cyc), 64'(r_e.cyc));
                    check("res_last", res_last, r_e.last);
                end
            end else if (res_q.size() > 0 && res_q[0].cyc <= cyc) begin
                fail_ev("res_missing");
                void'(res_q.pop_front());
            end
            if (err_short) begin
                if (err_q.size() == 0) fail_ev("err_unexpected");
                else check("err_cycle", 64'(cyc), 64'(err_q.pop_front()));
            end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
                fail_ev("err_missing");
                void'(err_q.pop_front());
            end
            check("credit_occ", credit_occ, occ_m);
            check("frame_cnt", frame_cnt, frame_m);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   nv;
        model_reset();
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_tready", tready, 1);
        check("rst_mat_we", mat_we, 0);
        check("rst_mat_row", mat_row, 0);
        check("rst_mat_wdata", mat_wdata, 0);
        check("rst_vec_valid", vec_valid, 0);
        check("rst_vec_data", vec_data, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_err_short", err_short, 0);
        check("rst_credit", credit_occ, 0);
        check("rst_frame", frame_cnt, 0);

        // nominal frame, then the same frame twice back to back
        nominal_frame(1);
        idle(6, 1);
        check("nominal_frames", frame_cnt, 1);
        nominal_frame(1);
        nominal_frame(1);
        idle(6, 1);
        check("b2b_frames", frame_cnt, 3);

        // credit backpressure with the FIFO never popped
        for (int r = 0; r < NROWS; r++) send(pack(r, r, r, r), 1'b0, 0);
        for (int v = 0; v < 4; v++) send(pack(v, 7, 7, 1), 1'b0, 0);
        step(1'b1, pack(5, 5, 5, 5), 1'b0, 1'b0, acc);
        check("bp_occ_full", credit_occ, 4);
        check("bp_ready_low", tready, 0);
        step(1'b1, pack(5, 5, 5, 5), 1'b0, 1'b1, acc);
        step(1'b1, pack(5, 5, 5, 5), 1'b0, 1'b0, acc);
        step(1'b1, pack(6, 6, 6, 6), 1'b0, 1'b0, acc);
        check("bp_one_more", credit_occ, 4);
        check("bp_ready_again", tready, 0);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        step(1'b1, pack(6, 6, 6, 6), 1'b0, 1'b1, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        check("acc_and_pop", credit_occ, 3);
        send(pack(7, 7, 7, 7), 1'b1, 0);
        idle(7, 1);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        check("pop_at_zero", credit_occ, 0);

        // short frame then a full recovery frame
        send(pack(1, 2, 3, 4), 1'b0, 1);
        send(pack(5, 6, 7, 8), 1'b1, 1);
        idle(2, 1);
        check("short_frames", frame_cnt, 4);
        nominal_frame(1);
        idle(6, 1);

        // random frames, gaps, random pops
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                nv = $urandom_range(1, NROWS);
                for (int r = 0; r < nv; r++)
                    send({$urandom, $urandom}, 1'(r == nv - 1), 2);
            end else begin
                for (int r = 0; r < NROWS; r++) begin
                    send({$urandom, $urandom}, 1'b0, 2);
                    if ($urandom_range(0, 2) == 0) idle(1, 2);
                end
                nv = $urandom_range(1, 6);
                for (int v = 0; v < nv; v++) begin
                    send({$urandom, $urandom}, 1'(v == nv - 1), 2);
                    if ($urandom_range(0, 2) == 0) idle(1, 2);
                end
            end
        end
        idle(10, 1);

        // reset with two vectors still in the datapath pipe
        for (int r = 0; r < NROWS; r++) send(pack(9, r, 9, r), 1'b0, 0);
        send(pack(1, 1, 1, 1), 1'b0, 0);
        send(pack(2, 2, 2, 2), 1'b0, 0);
        do_reset();
        idle(6, 0);
        check("mid_rst_credit", credit_occ, 0);
        check("mid_rst_frame", frame_cnt, 0);
        nominal_frame(1);
        idle(6, 1);

        check("mat_q_drained", 64'(mat_q.size()), 0);
        check("vec_q_drained", 64'(vec_q.size()), 0);
        check("res_q_drained", 64'(res_q.size()), 0);
        check("err_q_drained", 64'(err_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
